// File: rtl/cpu_clock_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_clock_sequencer
//
// Produces a one-cycle clock-enable stream for the processor core. The core
// runs on CLK and advances only in cycles where oCPU_EN is high. The enable
// stream is sequenced in one of four modes:
//   MANUAL : one enable per debounced step-key press
//   AUTO   : free-running enables every P cycles
//   BURST  : iBurstLen enables every P cycles, then back to MANUAL
//   HALT   : breakpoint stop; step keys still single-step, resume key exits
//
// Rate: P = max(fdiv,1) when fast, else max(fdiv,1) << SLOW_SHIFT.
//
// Ports
//   CLK          in   1   system clock (only clock in the block)
//   Reset        in   1   synchronous, active-high reset
//   iKEY         in   4   raw keys, active-low, asynchronous
//                         [3]=step [2]=auto/manual [1]=slow/fast [0]=resume
//   fdiv         in   8   rate divisor, 0 treated as 1
//   iBurstLen    in   16  number of enables in a burst
//   iBurstGo     in   1   one-cycle burst start request (MANUAL only)
//   iBreak       in   1   breakpoint level (honoured in AUTO/BURST only)
//   oCPU_EN      out  1   registered one-cycle clock enable
//   oMode        out  2   current mode: 0=MANUAL 1=AUTO 2=BURST 3=HALT
//                         (this is the FSM state register itself)
//   oFast        out  1   1 = fast rate selected
//   oCycleCount  out  32  enables issued since reset, wraps modulo 2^32
//
// Same-cycle event priority: Reset > iBreak > toggle > iBurstGo > step.
// Lower-priority events are dropped, never queued.
// -----------------------------------------------------------------------------
module cpu_clock_sequencer #(
    parameter int DEB_CYCLES = 16,
    parameter int SLOW_SHIFT = 18,
    parameter int CNT_W      = 26
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [3:0]  iKEY,
    input  logic [7:0]  fdiv,
    input  logic [15:0] iBurstLen,
    input  logic        iBurstGo,
    input  logic        iBreak,
    output logic        oCPU_EN,
    output logic [1:0]  oMode,
    output logic        oFast,
    output logic [31:0] oCycleCount
);

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_BURST  = 2'd2,
        MODE_HALT   = 2'd3
    } mode_t;

    localparam int KEY_STEP   = 3;
    localparam int KEY_TOGGLE = 2;
    localparam int KEY_RATE   = 1;
    localparam int KEY_RESUME = 0;

    // Counter wide enough to count up to DEB_CYCLES-1.
    localparam int              DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Key path: 2-FF synchronizer, then a debouncer per key.
    // The debounced level flips only after DEB_CYCLES consecutive synchronized
    // samples that disagree with it; any agreeing sample restarts the count.
    // A press is the debounced 1->0 flip, registered so it is high for exactly
    // one cycle. Keys idle at released (1) out of reset so no false press.
    // -------------------------------------------------------------------------
    logic [3:0]       key_sync1;
    logic [3:0]       key_sync2;
    logic [3:0]       key_level;
    logic [3:0]       key_press;
    logic [DEB_W-1:0] deb_cnt [4];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            key_sync1 <= 4'hF;
            key_sync2 <= 4'hF;
            key_level <= 4'hF;
            key_press <= 4'h0;
            for (int k = 0; k < 4; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            key_sync1 <= iKEY;
            key_sync2 <= key_sync1;
            key_press <= 4'h0;
            for (int k = 0; k < 4; k++) begin
                if (key_sync2[k] == key_level[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    deb_cnt[k]   <= '0;
                    key_level[k] <= key_sync2[k];
                    // Only the released->pressed direction is an event.
                    key_press[k] <= ~key_sync2[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end
        end
    end

    logic step_press;
    logic toggle_press;
    logic rate_press;
    logic resume_press;

    assign step_press   = key_press[KEY_STEP];
    assign toggle_press = key_press[KEY_TOGGLE];
    assign rate_press   = key_press[KEY_RATE];
    assign resume_press = key_press[KEY_RESUME];

    // -------------------------------------------------------------------------
    // Period selection. The compare uses >= rather than == so that lowering
    // fdiv (or switching slow->fast) while the counter is already past the new
    // terminal value fires on the next cycle instead of wrapping the counter.
    // -------------------------------------------------------------------------
    logic [7:0]       div_eff;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] period_last;
    logic [CNT_W-1:0] per_cnt;
    logic             pulse_due;

    assign div_eff     = (fdiv == 8'd0) ? 8'd1 : fdiv;
    assign period      = oFast ? CNT_W'(div_eff) : (CNT_W'(div_eff) << SLOW_SHIFT);
    assign period_last = period - CNT_W'(1);
    assign pulse_due   = (per_cnt >= period_last);

    // -------------------------------------------------------------------------
    // Mode FSM. All outputs are flops; oCPU_EN defaults low every cycle so any
    // enable is exactly one cycle wide.
    // -------------------------------------------------------------------------
    mode_t       mode;
    logic [15:0] remaining;

    assign oMode = mode;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            mode        <= MODE_MANUAL;
            oCPU_EN     <= 1'b0;
            oFast       <= 1'b0;
            per_cnt     <= '0;
            remaining   <= '0;
            oCycleCount <= '0;
        end else begin
            oCPU_EN <= 1'b0;

            // Counts the enable presented during the cycle now ending.
            oCycleCount <= oCycleCount + 32'(oCPU_EN);

            // Rate toggle is independent of mode; the new period is used from
            // the next comparison onward.
            if (rate_press) begin
                oFast <= ~oFast;
            end

            unique case (mode)
                MODE_MANUAL: begin
                    if (toggle_press) begin
                        mode    <= MODE_AUTO;
                        per_cnt <= '0;
                    end else if (iBurstGo && (iBurstLen != 16'd0)) begin
                        mode      <= MODE_BURST;
                        remaining <= iBurstLen;
                        per_cnt   <= '0;
                    end else if (step_press) begin
                        oCPU_EN <= 1'b1;
                    end
                end

                MODE_AUTO: begin
                    // A break in the same cycle as a due pulse swallows it.
                    if (iBreak) begin
                        mode <= MODE_HALT;
                    end else if (toggle_press) begin
                        mode <= MODE_MANUAL;
                    end else if (pulse_due) begin
                        oCPU_EN <= 1'b1;
                        per_cnt <= '0;
                    end else begin
                        per_cnt <= per_cnt + CNT_W'(1);
                    end
                end

                MODE_BURST: begin
                    if (iBreak) begin
                        mode <= MODE_HALT;
                    end else if (toggle_press) begin
                        mode <= MODE_MANUAL;
                    end else if (pulse_due) begin
                        oCPU_EN   <= 1'b1;
                        per_cnt   <= '0;
                        remaining <= remaining - 16'd1;
                        // This pulse is the last one; leave with it.
                        if (remaining <= 16'd1) begin
                            mode <= MODE_MANUAL;
                        end
                    end else begin
                        per_cnt <= per_cnt + CNT_W'(1);
                    end
                end

                MODE_HALT: begin
                    // Toggle and burst requests are ignored while halted.
                    if (resume_press) begin
                        mode <= MODE_MANUAL;
                    end else if (step_press) begin
                        oCPU_EN <= 1'b1;
                    end
                end

                default: begin
                    mode <= MODE_MANUAL;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_clock_sequencer.md
Name: cpu_clock_sequencer

Overview:
- Single-clock controller that generates a one-cycle CPU clock-enable (oCPU_EN) for the processor core.
- It replaces toggled derived clocks with an enable stream, so it sits between the board keys/debug interface and the core's clock-enable input.
- Sequences four modes: manual single-step, free-running auto (slow/fast divided rate), counted burst, and breakpoint halt.

Parameters:
DEB_CYCLES, 16, consecutive stable synchronized samples required to accept a key level change
SLOW_SHIFT, 18, slow-rate period = divisor << SLOW_SHIFT
CNT_W, 26, width of the period counter (must hold 255 << SLOW_SHIFT)

Ports:
CLK  input  1  system clock; the only clock in the block
Reset  input  1  synchronous, active-high reset
iKEY  input  4  raw board keys, active-low, asynchronous; [3]=step, [2]=auto/manual toggle, [1]=slow/fast toggle, [0]=resume from halt
fdiv  input  8  rate divisor; 0 treated as 1
iBurstLen  input  16  number of enables for a burst
iBurstGo  input  1  one-cycle burst start request
iBreak  input  1  level; breakpoint hit
oCPU_EN  output  1  registered one-cycle clock enable to the core
oMode  output  2  0=MANUAL, 1=AUTO, 2=BURST, 3=HALT
oFast  output  1  1=fast rate selected
oCycleCount  output  32  total enables issued since reset; wraps modulo 2^32

Behaviour:
- Reset (sampled at a CLK edge): all outputs 0; mode MANUAL; oFast=0; counters and burst remaining cleared.
  - Debounced key levels are set to released (1).
  - The synchronizers are also set to 1.
- Key path, per key:
  - 2-FF synchronizer, then debouncer.
  - The debounced level changes only after DEB_CYCLES consecutive synchronized samples that differ from it.
  - A press event is a debounced 1->0 transition and is high for exactly one cycle.
  - From the first edge that samples a raw key low (held low), the press event is high at edge DEB_CYCLES+2. A registered action follows one cycle later.
- Period: P = max(fdiv,1) when oFast=1, else max(fdiv,1) << SLOW_SHIFT.
  - The period counter clears on entry to AUTO or BURST.
  - An enable pulse fires when counter >= P-1, then the counter returns to 0. Using >= means a shrinking fdiv takes effect without a missed pulse.
  - The first pulse is therefore P cycles after entry. With fast and fdiv=1, oCPU_EN stays high every cycle.
- MANUAL:
  - Step press: oCPU_EN=1 for exactly one cycle.
  - Toggle press: go to AUTO.
  - iBurstGo with iBurstLen!=0: load remaining=iBurstLen and go to BURST. iBurstLen=0 is ignored.
- AUTO:
  - Periodic pulses as above.
  - Toggle press: go to MANUAL with no further pulse.
  - Step presses and iBurstGo are ignored.
- BURST:
  - Periodic pulses; each pulse decrements remaining.
  - The pulse that brings remaining to 0 is the last one; the next cycle is MANUAL.
  - Toggle press: abort to MANUAL.
- HALT entry and exit:
  - In AUTO or BURST, iBreak=1 in any cycle moves the mode to HALT at the next edge.
  - A pulse due in the same cycle iBreak=1 is suppressed.
  - In HALT: step press gives one enable (mode stays HALT); resume press (iKEY[0]) goes to MANUAL.
  - Toggle press and iBurstGo are ignored in HALT, and iBreak is ignored outside AUTO/BURST.
- oFast: the slow/fast press toggles it in any mode. The new rate applies from the next counter comparison.
- Simultaneous events, priority order: Reset > iBreak > toggle press > iBurstGo > step press. Lower-priority events in the same cycle are dropped, not queued.
- oCycleCount increments on every cycle oCPU_EN=1.
- oCPU_EN, oMode and oFast are driven directly from flops.

Test Plan:
- DEB_CYCLES=4. Reset, then hold iKEY[3]=0 for 20 cycles -> exactly one oCPU_EN pulse at edge 7 after the first low sample; oCycleCount=1. A 3-cycle glitch on iKEY[3] -> no pulse.
- Fast, fdiv=3, toggle to AUTO -> pulses at 3, 6, 9… cycles after entry. Change fdiv to 1 -> the next pulse arrives no later than one cycle later, then continuous. Set fdiv=0 -> behaves as 1.
- Slow, SLOW_SHIFT=2, fdiv=2 -> pulse spacing 8 cycles. A slow/fast press mid-run -> spacing 2.
- MANUAL, iBurstLen=5, fast, fdiv=2, pulse iBurstGo -> exactly 5 pulses 2 cycles apart, then oMode=0; oCycleCount +5. iBurstLen=0 -> stays MANUAL, no pulses.
- iBreak asserted in the same cycle as a due pulse in AUTO -> no pulse, oMode=3 next cycle. Step in HALT -> one pulse, oMode stays 3. Resume -> oMode=0.
- Reset asserted mid-burst (remaining=3) -> next cycle all outputs 0, MANUAL. Toggle press and iBurstGo in the same cycle -> AUTO, no burst.
